// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers GPR/CSR writes across flow-control stalls and commits them in order.
// Latency: 0 cycles when empty and unstalled, else queue position plus stalled cycles.
// Backpressure: ready drops only when full and stalled. Optional WB_FWD_EN adds pending-GPR forwarding.
module wb_commit_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       memwb_valid_i,
    output logic                       memwb_ready_o,
    input  logic [XLEN-1:0]            memwb_reg_wdata_i,
    input  logic [4:0]                 memwb_reg_waddr_i,
    input  logic                       memwb_reg_we_i,
    input  logic [XLEN-1:0]            memwb_csr_wdata_i,
    input  logic [11:0]                memwb_csr_waddr_i,
    input  logic                       memwb_csr_we_i,
    input  logic                       fc_stall_wb_i,
    output logic [XLEN-1:0]            wb_reg_wdata_o,
    output logic [4:0]                 wb_reg_waddr_o,
    output logic                       wb_reg_we_o,
    output logic [XLEN-1:0]            wb_csr_wdata_o,
    output logic [11:0]                wb_csr_waddr_o,
    output logic                       wb_csr_we_o,
    output logic                       wb_pending_o,
    output logic [$clog2(DEPTH+1)-1:0] wb_level_o,
    input  logic [4:0]                 fwd_raddr_i,
    output logic                       fwd_hit_o,
    output logic [XLEN-1:0]            fwd_data_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0] reg_wdata;
        logic [4:0]      reg_waddr;
        logic            reg_we;
        logic [XLEN-1:0] csr_wdata;
        logic [11:0]     csr_waddr;
        logic            csr_we;
    } entry_t;

    entry_t          q [DEPTH];
    entry_t          in_beat;
    entry_t          out_beat;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            accept;
    logic            bubble;
    logic            passthru;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // x0 writes are architecturally discarded, so clear the enable before anything looks at it.
    always_comb begin
        in_beat           = '0;
        in_beat.reg_wdata = memwb_reg_wdata_i;
        in_beat.reg_waddr = memwb_reg_waddr_i;
        in_beat.reg_we    = memwb_reg_we_i & (memwb_reg_waddr_i != 5'd0);
        in_beat.csr_wdata = memwb_csr_wdata_i;
        in_beat.csr_waddr = memwb_csr_waddr_i;
        in_beat.csr_we    = memwb_csr_we_i;
    end

    assign empty         = (count == '0);
    assign full          = (count == CW'(DEPTH));
    assign memwb_ready_o = rst_n & (~full | ~fc_stall_wb_i);
    assign accept        = memwb_valid_i & memwb_ready_o;
    assign bubble        = ~in_beat.reg_we & ~in_beat.csr_we;
    assign passthru      = accept & ~bubble & empty & ~fc_stall_wb_i;
    assign push          = accept & ~bubble & ~passthru;
    assign pop           = ~empty & ~fc_stall_wb_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= nxt(tail);
            if (pop)  head <= nxt(head);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[tail] <= in_beat;
    end

    // Data/address show the head even while stalled; only the enables are held off.
    always_comb begin
        out_beat = '0;
        if (!empty)        out_beat = q[head];
        else if (passthru) out_beat = in_beat;
        if (fc_stall_wb_i) begin
            out_beat.reg_we = 1'b0;
            out_beat.csr_we = 1'b0;
        end
        if (!rst_n) out_beat = '0;
    end

    assign wb_reg_wdata_o = out_beat.reg_wdata;
    assign wb_reg_waddr_o = out_beat.reg_waddr;
    assign wb_reg_we_o    = out_beat.reg_we;
    assign wb_csr_wdata_o = out_beat.csr_wdata;
    assign wb_csr_waddr_o = out_beat.csr_waddr;
    assign wb_csr_we_o    = out_beat.csr_we;
    assign wb_pending_o   = ~empty;
    assign wb_level_o     = count;

`ifdef WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so later matches overwrite; the incoming beat is youngest of all.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = PW'((int'(head) + k) % DEPTH);
            if (k < int'(count) && q[fwd_idx].reg_we && q[fwd_idx].reg_waddr == fwd_raddr_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = q[fwd_idx].reg_wdata;
            end
        end
        if (accept && in_beat.reg_we && in_beat.reg_waddr == fwd_raddr_i) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = in_beat.reg_wdata;
        end
        if (fwd_raddr_i == 5'd0 || !rst_n) begin
            fwd_hit_o  = 1'b0;
            fwd_data_o = '0;
        end
    end
`else
    logic [4:0] fwd_unused;
    assign fwd_unused = fwd_raddr_i;
    assign fwd_hit_o  = 1'b0;
    assign fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: directed beats, expected commits queued at issue and checked by a commit monitor.
module tb_wb_commit_queue;
    logic        clk;
    logic        rst_n;
    logic        memwb_valid_i;
    logic        memwb_ready_o;
    logic [31:0] memwb_reg_wdata_i;
    logic [4:0]  memwb_reg_waddr_i;
    logic        memwb_reg_we_i;
    logic [31:0] memwb_csr_wdata_i;
    logic [11:0] memwb_csr_waddr_i;
    logic        memwb_csr_we_i;
    logic        fc_stall_wb_i;
    logic [31:0] wb_reg_wdata_o;
    logic [4:0]  wb_reg_waddr_o;
    logic        wb_reg_we_o;
    logic [31:0] wb_csr_wdata_o;
    logic [11:0] wb_csr_waddr_o;
    logic        wb_csr_we_o;
    logic        wb_pending_o;
    logic [2:0]  wb_level_o;
    logic [4:0]  fwd_raddr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;

    typedef struct {
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic [31:0] reg_wdata;
        logic        csr_we;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    wb_commit_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .memwb_valid_i(memwb_valid_i), .memwb_ready_o(memwb_ready_o),
        .memwb_reg_wdata_i(memwb_reg_wdata_i), .memwb_reg_waddr_i(memwb_reg_waddr_i),
        .memwb_reg_we_i(memwb_reg_we_i), .memwb_csr_wdata_i(memwb_csr_wdata_i),
        .memwb_csr_waddr_i(memwb_csr_waddr_i), .memwb_csr_we_i(memwb_csr_we_i),
        .fc_stall_wb_i(fc_stall_wb_i),
        .wb_reg_wdata_o(wb_reg_wdata_o), .wb_reg_waddr_o(wb_reg_waddr_o), .wb_reg_we_o(wb_reg_we_o),
        .wb_csr_wdata_o(wb_csr_wdata_o), .wb_csr_waddr_o(wb_csr_waddr_o), .wb_csr_we_o(wb_csr_we_o),
        .wb_pending_o(wb_pending_o), .wb_level_o(wb_level_o),
        .fwd_raddr_i(fwd_raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at the following posedge+1 with valid dropped.
    task automatic send(input logic [4:0] ra, input logic [31:0] rd, input logic rwe,
                        input logic [11:0] ca, input logic [31:0] cd, input logic cwe);
        int   waited;
        exp_t e;
        waited            = 0;
        memwb_valid_i     = 1'b1;
        memwb_reg_waddr_i = ra;
        memwb_reg_wdata_i = rd;
        memwb_reg_we_i    = rwe;
        memwb_csr_waddr_i = ca;
        memwb_csr_wdata_i = cd;
        memwb_csr_we_i    = cwe;
        #1;
        while (!memwb_ready_o && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        tests++;
        if (!memwb_ready_o) begin
            fails++;
            $display("FAIL send_ready: ready stayed 0, expected 1 within 20 cycles");
        end else if ((rwe && ra != 5'd0) || cwe) begin
            e.reg_we = rwe && ra != 5'd0; e.reg_waddr = ra; e.reg_wdata = rd;
            e.csr_we = cwe;               e.csr_waddr = ca; e.csr_wdata = cd;
            exp_q.push_back(e);
        end
        if (fc_stall_wb_i) check("stall_no_we", {62'd0, wb_reg_we_o, wb_csr_we_o}, 64'd0);
        tick();
        memwb_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && (wb_reg_we_o || wb_csr_we_o)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_commit: got reg_we=%0b x%0d=0x%0h csr_we=%0b 0x%0h=0x%0h, expected no commit",
                         wb_reg_we_o, wb_reg_waddr_o, wb_reg_wdata_o, wb_csr_we_o, wb_csr_waddr_o, wb_csr_wdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wb_reg_we_o !== e.reg_we || wb_csr_we_o !== e.csr_we ||
                    (e.reg_we && (wb_reg_waddr_o !== e.reg_waddr || wb_reg_wdata_o !== e.reg_wdata)) ||
                    (e.csr_we && (wb_csr_waddr_o !== e.csr_waddr || wb_csr_wdata_o !== e.csr_wdata))) begin
                    fails++;
                    $display("FAIL commit: got reg %0b x%0d=0x%0h csr %0b 0x%0h=0x%0h, expected reg %0b x%0d=0x%0h csr %0b 0x%0h=0x%0h",
                             wb_reg_we_o, wb_reg_waddr_o, wb_reg_wdata_o, wb_csr_we_o, wb_csr_waddr_o, wb_csr_wdata_o,
                             e.reg_we, e.reg_waddr, e.reg_wdata, e.csr_we, e.csr_waddr, e.csr_wdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; memwb_valid_i = 1'b0; fc_stall_wb_i = 1'b0; fwd_raddr_i = 5'd0;
        memwb_reg_wdata_i = '0; memwb_reg_waddr_i = '0; memwb_reg_we_i = 1'b0;
        memwb_csr_wdata_i = '0; memwb_csr_waddr_i = '0; memwb_csr_we_i = 1'b0;
        #2;
        check("rst_ready", {63'd0, memwb_ready_o}, 64'd0);
        check("rst_we", {62'd0, wb_reg_we_o, wb_csr_we_o}, 64'd0);
        check("rst_level", {61'd0, wb_level_o}, 64'd0);
        check("rst_pending", {63'd0, wb_pending_o}, 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {63'd0, memwb_ready_o}, 64'd1);
        tick();

        // Pass-through on an empty, unstalled queue
        send(5'd5, 32'h1234, 1'b1, 12'h0, 32'h0, 1'b0);
        check("pass_level", {61'd0, wb_level_o}, 64'd0);

        // Stall buffering
        fc_stall_wb_i = 1'b1;
        send(5'd1, 32'hA, 1'b1, 12'h0, 32'h0, 1'b0);
        send(5'd2, 32'hB, 1'b1, 12'h0, 32'h0, 1'b0);
        send(5'd0, 32'h0, 1'b0, 12'h300, 32'hC, 1'b1);
        check("stall_level", {61'd0, wb_level_o}, 64'd3);
        check("stall_pending", {63'd0, wb_pending_o}, 64'd1);
        fc_stall_wb_i = 1'b0;
        tick(); tick(); tick();
        check("drain_level", {61'd0, wb_level_o}, 64'd0);

        // Full back-pressure with same-edge pop and push
        fc_stall_wb_i = 1'b1;
        for (int i = 0; i < 4; i++) send(5'(3 + i), 32'(8'h30 + i), 1'b1, 12'h0, 32'h0, 1'b0);
        check("full_level", {61'd0, wb_level_o}, 64'd4);
        memwb_valid_i = 1'b1; memwb_reg_waddr_i = 5'd8; memwb_reg_wdata_i = 32'h50; memwb_reg_we_i = 1'b1;
        memwb_csr_we_i = 1'b0;
        #1;
        check("full_ready", {63'd0, memwb_ready_o}, 64'd0);
        tick();
        fc_stall_wb_i = 1'b0;
        #1;
        check("full_drain_ready", {63'd0, memwb_ready_o}, 64'd1);
        exp_q.push_back('{1'b1, 5'd8, 32'h50, 1'b0, 12'h0, 32'h0});
        tick();
        memwb_valid_i = 1'b0;
        check("full_swap_level", {61'd0, wb_level_o}, 64'd4);
        tick(); tick(); tick(); tick();
        check("full_drain_level", {61'd0, wb_level_o}, 64'd0);

        // x0 write with no CSR write is a bubble
        memwb_valid_i = 1'b1; memwb_reg_waddr_i = 5'd0; memwb_reg_wdata_i = 32'hFFFF; memwb_reg_we_i = 1'b1;
        memwb_csr_we_i = 1'b0;
        #1;
        check("bubble_ready", {63'd0, memwb_ready_o}, 64'd1);
        check("bubble_we", {62'd0, wb_reg_we_o, wb_csr_we_o}, 64'd0);
        tick();
        memwb_valid_i = 1'b0;
        check("bubble_level", {61'd0, wb_level_o}, 64'd0);

        // Forwarding of pending GPR values
        fc_stall_wb_i = 1'b1;
        send(5'd7, 32'h11, 1'b1, 12'h0, 32'h0, 1'b0);
        send(5'd7, 32'h22, 1'b1, 12'h0, 32'h0, 1'b0);
        fwd_raddr_i = 5'd7;
        #1;
`ifdef WB_FWD_EN
        check("fwd_hit7", {63'd0, fwd_hit_o}, 64'd1);
        check("fwd_data7", {32'd0, fwd_data_o}, 64'h22);
`else
        check("fwd_hit7_off", {63'd0, fwd_hit_o}, 64'd0);
        check("fwd_data7_off", {32'd0, fwd_data_o}, 64'd0);
`endif
        fwd_raddr_i = 5'd0;
        #1;
        check("fwd_hit0", {63'd0, fwd_hit_o}, 64'd0);
        tick();
        fwd_raddr_i = 5'd7;
        send(5'd7, 32'h33, 1'b1, 12'h0, 32'h0, 1'b0);
        check("fwd_level", {61'd0, wb_level_o}, 64'd3);
        memwb_valid_i = 1'b1; memwb_reg_waddr_i = 5'd7; memwb_reg_wdata_i = 32'h44; memwb_reg_we_i = 1'b1;
        #1;
`ifdef WB_FWD_EN
        check("fwd_incoming", {32'd0, fwd_data_o}, 64'h44);
`else
        check("fwd_incoming_off", {63'd0, fwd_hit_o}, 64'd0);
`endif
        memwb_valid_i = 1'b0;
        tick();

        // Async reset mid-cycle with three entries queued
        fc_stall_wb_i = 1'b0;
        #1;
        check("pre_rst_we", {63'd0, wb_reg_we_o}, 64'd1);
        check("pre_rst_data", {32'd0, wb_reg_wdata_o}, 64'h11);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", {62'd0, wb_reg_we_o, wb_csr_we_o}, 64'd0);
        check("mid_rst_level", {61'd0, wb_level_o}, 64'd0);
        check("mid_rst_ready", {63'd0, memwb_ready_o}, 64'd0);
        check("mid_rst_fwd", {63'd0, fwd_hit_o}, 64'd0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_level", {61'd0, wb_level_o}, 64'd0);
        check("post_rst_pending", {63'd0, wb_pending_o}, 64'd0);
        tick(); tick(); tick();
        check("post_rst_we", {62'd0, wb_reg_we_o, wb_csr_we_o}, 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Parametrised writeback stage sitting between the mem_wb pipeline register and the GPR/CSR register files.
- Unlike the plain WB stage, a stall from flow control does not drop writebacks. Pending GPR/CSR writes are held in a DEPTH-entry in-order queue and drained one per non-stalled cycle.
- When the queue is full, back-pressure is applied to mem_wb.
- An optional lookup port forwards pending (uncommitted) GPR values to decode.

Parameters:
- XLEN, 32, data width of GPR and CSR write data.
- DEPTH, 4, queue entries; any value >= 1; pointers wrap modulo DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- memwb_valid_i  input  1  beat present from mem_wb.
- memwb_ready_o  output  1  beat accepted this cycle (accept = valid & ready).
- memwb_reg_wdata_i  input  XLEN  GPR write data.
- memwb_reg_waddr_i  input  5  GPR write address.
- memwb_reg_we_i  input  1  GPR write enable.
- memwb_csr_wdata_i  input  XLEN  CSR write data.
- memwb_csr_waddr_i  input  12  CSR write address.
- memwb_csr_we_i  input  1  CSR write enable.
- fc_stall_wb_i  input  1  flow-control stall; no commit while high.
- wb_reg_wdata_o  output  XLEN  to regs.
- wb_reg_waddr_o  output  5  to regs.
- wb_reg_we_o  output  1  to regs.
- wb_csr_wdata_o  output  XLEN  to csr.
- wb_csr_waddr_o  output  12  to csr.
- wb_csr_we_o  output  1  to csr.
- wb_pending_o  output  1  queue non-empty.
- wb_level_o  output  $clog2(DEPTH+1)  current entry count.
- fwd_raddr_i  input  5  GPR address probed by decode.
- fwd_hit_o  output  1  pending write to fwd_raddr_i exists.
- fwd_data_o  output  XLEN  youngest pending value for fwd_raddr_i.

Behaviour:
- Reset (async, rst_n low):
  - count = 0; head and tail pointers = 0.
  - wb_reg_we_o, wb_csr_we_o, fwd_hit_o and memwb_ready_o are forced 0 while rst_n is low.
  - Data/address outputs are 0 and wb_level_o is 0.
- Beat sanitising:
  - GPR write to x0 has its reg we cleared.
  - A beat with both enables 0 after sanitising is a bubble: accepted, never enqueued, never committed.
- Ready: memwb_ready_o = (count < DEPTH) | ~fc_stall_wb_i. A full queue that is draining accepts a new beat in the same cycle.
- Commit source, evaluated combinationally each cycle:
  - Stall high: both we outputs are 0 and data/address outputs hold the head entry (0 if empty). Nothing is popped.
  - Stall low, count > 0: outputs drive the head entry; pop at the clock edge.
  - Stall low, count == 0, accepted non-bubble beat: zero-latency pass-through of the sanitised input; not enqueued.
  - Otherwise: we outputs are 0.
- Enqueue: an accepted non-bubble beat is written at tail on the edge, unless it was passed through.
- Simultaneous pop and push: count is unchanged and both pointers advance.
- Ordering: strict in-order commit; GPR and CSR parts of one beat commit in the same cycle.
- Latency: 0 cycles when the queue is empty and unstalled; otherwise equal to queue position + stalled cycles.
- Overflow cannot occur by construction. A push when count == DEPTH with stall high is blocked by ready = 0.
- Reset mid-operation discards all queued entries with no commit.
- wb_pending_o = (count != 0); wb_level_o = count (registered).

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - The lookup searches all valid queue entries plus the current accepted non-bubble beat.
  - Youngest wins: incoming beat > tail-1 > ... > head.
  - Only entries with reg we set and waddr == fwd_raddr_i count; fwd_raddr_i == 0 never hits.
  - fwd_hit_o and fwd_data_o are combinational.
- Undefined: fwd_hit_o = 0 and fwd_data_o = 0 constantly. The ports remain and the search logic is not synthesised.

Test Plan:
- Pass-through: queue empty, stall 0, beat reg x5 = 0x1234 -> wb_reg_we_o = 1 with addr 5 and data 0x1234 in the same cycle; wb_level_o stays 0.
- Stall buffering: stall 1 for 3 cycles while beats x1 = 0xA, x2 = 0xB, csr 0x300 = 0xC arrive.
  - While stalled: no we pulses; level reaches 3.
  - After stall drops: three consecutive commits in order A, B, C; the CSR commit has wb_csr_we_o = 1 with addr 0x300.
- Full back-pressure (DEPTH = 4): stall 1, push 4 beats -> ready = 0 on the 5th. Drop the stall with the 5th beat still valid -> head pops and the 5th is enqueued the same edge; level stays 4.
- x0 and bubble: beat reg x0 = 0xFFFF with csr we 0 -> accepted, never committed, level unchanged.
- Forwarding (WB_FWD_EN): queued x7 = 0x11, then x7 = 0x22, probe 7 -> hit, data 0x22. Probe 0 -> no hit. Without the macro -> hit 0.
- Async reset: assert rst_n low mid-cycle with 3 entries queued -> we outputs drop immediately. After release, level is 0 and nothing commits.
